// File: rtl/coolgirl_config_ctrl_pkg.sv
// Shared definitions for the COOLGIRL configuration controller: register map,
// status byte layout and the configuration bank structure.
package coolgirl_cfg_pkg;

   // Register indices within the mirrored $5000-$5FFF window
   localparam logic [2:0] REG_BASE_HI  = 3'd0;
   localparam logic [2:0] REG_BASE_LO  = 3'd1;
   localparam logic [2:0] REG_PRG_MASK = 3'd2;
   localparam logic [2:0] REG_CHR_MASK = 3'd3;
   localparam logic [2:0] REG_MAPPER   = 3'd4;
   localparam logic [2:0] REG_FLAGS    = 3'd5;
   localparam logic [2:0] REG_COMMIT   = 3'd6;
   localparam logic [2:0] REG_STATUS   = 3'd7;

   // CPU A14..A12 pattern selecting the register window
   localparam logic [2:0] SELECT_PAGE = 3'b101;

   // Status byte bit positions
   localparam int unsigned STAT_LOCKOUT   = 7;
   localparam int unsigned STAT_PENDING   = 6;
   localparam int unsigned STAT_COUNT_MSB = 3;
   localparam int unsigned STAT_COUNT_LSB = 0;

   // One complete configuration bank (staging or live)
   typedef struct packed {
      logic [12:0] cpu_base;
      logic [6:0]  prg_mask;
      logic [4:0]  chr_mask;
      logic [5:0]  mapper;
      logic        map_rom_on_6000;
      logic        sram_enabled;
      logic        prg_write_enabled;
      logic        chr_write_enabled;
      logic        four_screen;
      logic [1:0]  sram_page;
   } cfg_t;

   // Reset bank with the standard 32 KB menu window and 8 KB CHR masks
   localparam cfg_t CFG_RESET = '{
      cpu_base:          13'd0,
      prg_mask:          7'h7E,
      chr_mask:          5'h1F,
      mapper:            6'd0,
      map_rom_on_6000:   1'b0,
      sram_enabled:      1'b0,
      prg_write_enabled: 1'b0,
      chr_write_enabled: 1'b0,
      four_screen:       1'b0,
      sram_page:         2'd0
   };

   // Reset bank with caller-supplied mask defaults
   function automatic cfg_t cfg_reset_with(input logic [6:0] prg, input logic [4:0] chr);
      cfg_t c;
      c = CFG_RESET;
      c.prg_mask = prg;
      c.chr_mask = chr;
      return c;
   endfunction

endpackage

// File: rtl/coolgirl_cfg_commit_timer.sv
// Reloadable down counter that delays the live update after a commit write.
// fire is high on the edge where the count reaches zero; a reload on that
// same edge wins and postpones the update.
module coolgirl_cfg_commit_timer (
   input  logic       m2,
   input  logic       reset,
   input  logic       load,
   input  logic [3:0] load_value,
   output logic       pending,
   output logic [3:0] count,
   output logic       fire
);

   logic [3:0] count_r;
   logic       pending_r;
   logic       fire_s;

   assign fire_s  = pending_r & ~load & (count_r <= 4'd1);
   assign pending = pending_r;
   assign count   = count_r;
   assign fire    = fire_s;

   // Count down once per falling m2 edge while a commit is pending
   always_ff @(negedge m2 or posedge reset) begin
      if (reset) begin
         count_r   <= 4'd0;
         pending_r <= 1'b0;
      end else if (load) begin
         count_r   <= load_value;
         pending_r <= 1'b1;
      end else if (fire_s) begin
         count_r   <= 4'd0;
         pending_r <= 1'b0;
      end else if (pending_r) begin
         count_r   <= count_r - 4'd1;
         pending_r <= 1'b1;
      end else begin
         count_r   <= count_r;
         pending_r <= pending_r;
      end
   end

endmodule

// File: rtl/coolgirl_config_ctrl.sv
// CPU-visible configuration controller: stages register writes in $5000-$5FFF,
// commits the whole bank atomically after a delay, optionally locking it.
module coolgirl_config_ctrl
   import coolgirl_cfg_pkg::*;
#(
   parameter int         COMMIT_DELAY = 4,
   parameter logic [4:0] VERSION      = 5'd2,
   parameter logic [6:0] DEF_PRG_MASK = 7'h7E,
   parameter logic [4:0] DEF_CHR_MASK = 5'h1F
) (
   input  logic        m2,
   input  logic        reset,
   input  logic        romsel,
   input  logic        cpu_rw_in,
   input  logic [14:0] cpu_addr_in,
   input  logic [7:0]  cpu_data_in,
   output logic [7:0]  cpu_data_out,
   output logic        cpu_data_out_enabled,
   output logic [12:0] cpu_base,
   output logic [6:0]  prg_mask,
   output logic [4:0]  chr_mask,
   output logic [5:0]  mapper,
   output logic        map_rom_on_6000,
   output logic        sram_enabled,
   output logic        prg_write_enabled,
   output logic        chr_write_enabled,
   output logic        four_screen,
   output logic [1:0]  sram_page,
   output logic        lockout
);

   localparam logic [3:0] COMMIT_LOAD = COMMIT_DELAY[3:0];
   localparam cfg_t       CFG_DEF     = cfg_reset_with(DEF_PRG_MASK, DEF_CHR_MASK);

   cfg_t       staging_r;
   cfg_t       live_r;
   cfg_t       staging_next_s;
   logic       lock_req_r;
   logic       lockout_r;
   logic       select_s;
   logic [2:0] idx_s;
   logic       write_s;
   logic       commit_s;
   logic       pending_s;
   logic [3:0] count_s;
   logic       fire_s;
   logic [7:0] status_s;
   logic       addr_unused_s;

   assign select_s      = romsel & (cpu_addr_in[14:12] == SELECT_PAGE);
   assign idx_s         = cpu_addr_in[2:0];
   assign write_s       = select_s & ~cpu_rw_in & ~lockout_r;
   assign commit_s      = write_s & (idx_s == REG_COMMIT);
   assign addr_unused_s = ^{cpu_addr_in[11:3], VERSION};

   coolgirl_cfg_commit_timer u_timer (
      .m2         (m2),
      .reset      (reset),
      .load       (commit_s),
      .load_value (COMMIT_LOAD),
      .pending    (pending_s),
      .count      (count_s),
      .fire       (fire_s)
   );

   // Merge the addressed register field into a copy of the staging bank
   always_comb begin
      staging_next_s = staging_r;
      case (idx_s)
         REG_BASE_HI:  staging_next_s.cpu_base[12:8] = cpu_data_in[4:0];
         REG_BASE_LO:  staging_next_s.cpu_base[7:0]  = cpu_data_in;
         REG_PRG_MASK: staging_next_s.prg_mask       = cpu_data_in[6:0];
         REG_CHR_MASK: staging_next_s.chr_mask       = cpu_data_in[4:0];
         REG_MAPPER: begin
            staging_next_s.mapper          = cpu_data_in[5:0];
            staging_next_s.map_rom_on_6000 = cpu_data_in[7];
         end
         REG_FLAGS: begin
            staging_next_s.sram_page         = cpu_data_in[1:0];
            staging_next_s.sram_enabled      = cpu_data_in[2];
            staging_next_s.chr_write_enabled = cpu_data_in[3];
            staging_next_s.prg_write_enabled = cpu_data_in[4];
            staging_next_s.four_screen       = cpu_data_in[5];
         end
         default: staging_next_s = staging_r;
      endcase
   end

   // Staging bank and requested lock bit, written by the CPU
   always_ff @(negedge m2 or posedge reset) begin
      if (reset) begin
         staging_r  <= CFG_DEF;
         lock_req_r <= 1'b0;
      end else if (write_s) begin
         staging_r  <= staging_next_s;
         lock_req_r <= commit_s ? cpu_data_in[7] : lock_req_r;
      end else begin
         staging_r  <= staging_r;
         lock_req_r <= lock_req_r;
      end
   end

   // Live bank and lockout, updated together only when the timer fires
   always_ff @(negedge m2 or posedge reset) begin
      if (reset) begin
         live_r    <= CFG_DEF;
         lockout_r <= 1'b0;
      end else if (fire_s) begin
         live_r    <= staging_r;
         lockout_r <= lock_req_r;
      end else begin
         live_r    <= live_r;
         lockout_r <= lockout_r;
      end
   end

   // Status byte assembled straight from flops
   always_comb begin
      status_s = 8'h00;
      status_s[STAT_LOCKOUT] = lockout_r;
      status_s[STAT_PENDING] = pending_s;
      status_s[STAT_COUNT_MSB:STAT_COUNT_LSB] = count_s;
   end

   assign cpu_data_out         = status_s;
   assign cpu_data_out_enabled = m2 & cpu_rw_in & select_s & (idx_s == REG_STATUS);

   assign cpu_base          = live_r.cpu_base;
   assign prg_mask          = live_r.prg_mask;
   assign chr_mask          = live_r.chr_mask;
   assign mapper            = live_r.mapper;
   assign map_rom_on_6000   = live_r.map_rom_on_6000;
   assign sram_enabled      = live_r.sram_enabled;
   assign prg_write_enabled = live_r.prg_write_enabled;
   assign chr_write_enabled = live_r.chr_write_enabled;
   assign four_screen       = live_r.four_screen;
   assign sram_page         = live_r.sram_page;
   assign lockout           = lockout_r;

endmodule
